// File: rtl/intr_ack_sequencer.sv
// -----------------------------------------------------------------------------
// intr_ack_sequencer
//
// Purpose:
//   Runs the CPU interrupt-acknowledge cycle for an 8259A-compatible interrupt
//   controller. It raises INT toward the CPU and counts INTA pulses: two in
//   8086 mode, three in 8080/85 mode. On the first INTA it latches the winning
//   level and pulses the in-service set. During the INTA low phases it drives
//   the CALL opcode, the vector, or the call-address bytes. When automatic EOI
//   is enabled, it pulses the in-service clear once the cycle ends.
//
// Ports:
//   clk                         system clock
//   reset                       synchronous, active-high reset
//   int_request                 resolver has an unmasked request that wins
//   highest_priority_interrupt  one-hot winning level from the resolver
//   inta_n                      CPU interrupt acknowledge (active low)
//   mode_8086                   1 = 8086 (2 INTA), 0 = 8080/85 (3 INTA)
//   aeoi                        automatic EOI enabled
//   vector_base                 T7-T3 of the 8086 vector
//   call_addr_low               A7-A5 of the 8080 CALL address
//   call_addr_high              A15-A8 of the 8080 CALL address
//   adi                         call address interval: 1 = 4 bytes, 0 = 8
//   int_out                     INT pin to the CPU
//   acknowledge                 high from the first INTA fall to sequence end
//   isr_set                     one-cycle one-hot in-service set pulse
//   eoi_clear                   one-cycle one-hot automatic EOI clear pulse
//   data_out / data_out_en      byte and enable for the data bus buffer
//   acked_level                 level latched at the first INTA
//   state_dbg                   current FSM state, for observation
//
// Handshake: inta_n is sampled on clk. All decisions are taken on single-cycle
// fall/rise strobes, which compare the live pin with its one-cycle-old copy.
// -----------------------------------------------------------------------------
module intr_ack_sequencer #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               int_request,
    input  logic [NUM_IRQ-1:0] highest_priority_interrupt,
    input  logic               inta_n,
    input  logic               mode_8086,
    input  logic               aeoi,
    input  logic [4:0]         vector_base,
    input  logic [2:0]         call_addr_low,
    input  logic [7:0]         call_addr_high,
    input  logic               adi,
    output logic               int_out,
    output logic               acknowledge,
    output logic [NUM_IRQ-1:0] isr_set,
    output logic [NUM_IRQ-1:0] eoi_clear,
    output logic [7:0]         data_out,
    output logic               data_out_en,
    output logic [2:0]         acked_level,
    output logic [2:0]         state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ACK1  = 3'd2,
        WAIT2 = 3'd3,
        ACK2  = 3'd4,
        WAIT3 = 3'd5,
        ACK3  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [NUM_IRQ-1:0] ONE_HOT_BASE = 1;
    localparam logic [7:0]         CALL_OPCODE  = 8'hCD;

    state_t             state_q;
    logic               inta_q;
    logic               spurious_q;
    logic               int_out_q;
    logic               ack_q;
    logic [NUM_IRQ-1:0] isr_set_q;
    logic [NUM_IRQ-1:0] eoi_clear_q;
    logic [7:0]         data_q;
    logic               data_en_q;
    logic [2:0]         level_q;

    logic               fall;
    logic               rise;
    logic [2:0]         win_level_d;
    logic               win_valid_d;
    logic [7:0]         byte2_d;

    assign fall = inta_q & ~inta_n;
    assign rise = ~inta_q & inta_n;

    // Lowest set bit wins. An empty resolver output means the request
    // vanished before INTA, which is a spurious cycle reported as level 7.
    always_comb begin
        win_level_d = 3'd7;
        win_valid_d = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (highest_priority_interrupt[i]) begin
                win_level_d = 3'(i);
                win_valid_d = 1'b1;
            end
        end
    end

    // The second byte depends on the mode: the 8086 vector, or the low
    // CALL address byte with its 4- or 8-byte interval.
    always_comb begin
        byte2_d = {vector_base, level_q};
        if (!mode_8086) begin
            if (adi) begin
                byte2_d = {call_addr_low, level_q, 2'b00};
            end else begin
                byte2_d = {call_addr_low[2:1], level_q, 3'b000};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            inta_q      <= 1'b1;
            spurious_q  <= 1'b0;
            int_out_q   <= 1'b0;
            ack_q       <= 1'b0;
            isr_set_q   <= '0;
            eoi_clear_q <= '0;
            data_q      <= 8'h00;
            data_en_q   <= 1'b0;
            level_q     <= 3'd0;
        end else begin
            inta_q      <= inta_n;
            isr_set_q   <= '0;
            eoi_clear_q <= '0;
            case (state_q)
                IDLE: begin
                    int_out_q <= 1'b0;
                    data_en_q <= 1'b0;
                    data_q    <= 8'h00;
                    if (int_request) begin
                        int_out_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    // An INTA fall takes priority over a request withdrawn
                    // in the same cycle: the CPU has already committed.
                    if (fall) begin
                        level_q    <= win_level_d;
                        spurious_q <= ~win_valid_d;
                        isr_set_q  <= win_valid_d ? (ONE_HOT_BASE << win_level_d) : '0;
                        ack_q      <= 1'b1;
                        int_out_q  <= 1'b0;
                        if (!mode_8086) begin
                            data_q    <= CALL_OPCODE;
                            data_en_q <= 1'b1;
                        end
                        state_q <= ACK1;
                    end else if (!int_request) begin
                        int_out_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                ACK1: begin
                    if (rise) begin
                        data_en_q <= 1'b0;
                        data_q    <= 8'h00;
                        state_q   <= WAIT2;
                    end
                end
                WAIT2: begin
                    if (fall) begin
                        data_en_q <= 1'b1;
                        data_q    <= byte2_d;
                        state_q   <= ACK2;
                    end
                end
                ACK2: begin
                    if (rise) begin
                        data_en_q <= 1'b0;
                        data_q    <= 8'h00;
                        if (mode_8086) begin
                            ack_q       <= 1'b0;
                            eoi_clear_q <= (aeoi && !spurious_q) ? (ONE_HOT_BASE << level_q) : '0;
                            state_q     <= DONE;
                        end else begin
                            state_q <= WAIT3;
                        end
                    end else begin
                        data_q <= byte2_d;
                    end
                end
                WAIT3: begin
                    if (fall) begin
                        data_en_q <= 1'b1;
                        data_q    <= call_addr_high;
                        state_q   <= ACK3;
                    end
                end
                ACK3: begin
                    if (rise) begin
                        data_en_q   <= 1'b0;
                        data_q      <= 8'h00;
                        ack_q       <= 1'b0;
                        eoi_clear_q <= (aeoi && !spurious_q) ? (ONE_HOT_BASE << level_q) : '0;
                        state_q     <= DONE;
                    end else begin
                        data_q <= call_addr_high;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign int_out     = int_out_q;
    assign acknowledge = ack_q;
    assign isr_set     = isr_set_q;
    assign eoi_clear   = eoi_clear_q;
    assign data_out    = data_q;
    assign data_out_en = data_en_q;
    assign acked_level = level_q;
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_intr_ack_sequencer.sv
module tb_intr_ack_sequencer;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_ACK1  = 3'd2;
  localparam logic [2:0] S_WAIT2 = 3'd3;
  localparam logic [2:0] S_ACK2  = 3'd4;
  localparam logic [2:0] S_WAIT3 = 3'd5;
  localparam logic [2:0] S_ACK3  = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic       clk;
  logic       reset;
  logic       int_request;
  logic [7:0] hpi;
  logic       inta_n;
  logic       mode_8086;
  logic       aeoi;
  logic [4:0] vector_base;
  logic [2:0] call_addr_low;
  logic [7:0] call_addr_high;
  logic       adi;
  logic       int_out;
  logic       acknowledge;
  logic [7:0] isr_set;
  logic [7:0] eoi_clear;
  logic [7:0] data_out;
  logic       data_out_en;
  logic [2:0] acked_level;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_pass = 0;
  logic [32:0] e;

  intr_ack_sequencer #(.NUM_IRQ(8)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .int_request                (int_request),
    .highest_priority_interrupt (hpi),
    .inta_n                     (inta_n),
    .mode_8086                  (mode_8086),
    .aeoi                       (aeoi),
    .vector_base                (vector_base),
    .call_addr_low              (call_addr_low),
    .call_addr_high             (call_addr_high),
    .adi                        (adi),
    .int_out                    (int_out),
    .acknowledge                (acknowledge),
    .isr_set                    (isr_set),
    .eoi_clear                  (eoi_clear),
    .data_out                   (data_out),
    .data_out_en                (data_out_en),
    .acked_level                (acked_level),
    .state_dbg                  (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fields: {int_out, acknowledge, isr_set, eoi_clear, data_out, data_out_en, acked_level, state}
  function automatic logic [32:0] obs();
    return {int_out, acknowledge, isr_set, eoi_clear, data_out, data_out_en, acked_level, state_dbg};
  endfunction

  function automatic logic [32:0] ev(input logic io, input logic ack, input logic [7:0] isr,
                                     input logic [7:0] eoi, input logic [7:0] d, input logic en,
                                     input logic [2:0] lvl, input logic [2:0] st);
    return {io, ack, isr, eoi, d, en, lvl, st};
  endfunction

  // driver: advance one clock and settle past the active edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; int_request = 1'b0; hpi = 8'h00; inta_n = 1'b1;
    mode_8086 = 1'b1; aeoi = 1'b0; vector_base = 5'd0; call_addr_low = 3'd0;
    call_addr_high = 8'h00; adi = 1'b0;
    tick(); tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL reset_values got=%h exp=%h", obs(), e); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_8086_normal();
    mode_8086 = 1'b1; aeoi = 1'b0; vector_base = 5'b01000; hpi = 8'h04; int_request = 1'b1;
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL int_out_before_edge got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_REQ); n_checks++;
    if (obs() !== e) $display("FAIL int_out_rise got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; int_request = 1'b0; tick();
    e = ev(0, 1, 8'h04, 8'h00, 8'h00, 0, 3'd2, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL first_fall_isr got=%h exp=%h", obs(), e); else n_pass++;
    hpi = 8'h01; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL isr_one_cycle got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_WAIT2); n_checks++;
    if (obs() !== e) $display("FAIL wait2 got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h42, 1, 3'd2, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL vector_byte got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL done_no_eoi got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL back_to_idle got=%h exp=%h", obs(), e); else n_pass++;
  endtask

  task automatic test_8086_aeoi();
    mode_8086 = 1'b1; aeoi = 1'b1; vector_base = 5'b01000; hpi = 8'h04; int_request = 1'b1;
    tick();
    inta_n = 1'b0; int_request = 1'b0; tick();
    e = ev(0, 1, 8'h04, 8'h00, 8'h00, 0, 3'd2, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL aeoi_isr got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h42, 1, 3'd2, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL aeoi_vector got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h04, 8'h00, 0, 3'd2, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL aeoi_pulse got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL aeoi_one_cycle got=%h exp=%h", obs(), e); else n_pass++;
    aeoi = 1'b0;
  endtask

  task automatic test_8080_adi1();
    mode_8086 = 1'b0; adi = 1'b1; hpi = 8'h20; call_addr_low = 3'b101; call_addr_high = 8'h3F;
    int_request = 1'b1; tick();
    e = ev(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd2, S_REQ); n_checks++;
    if (obs() !== e) $display("FAIL c80_req got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; int_request = 1'b0; tick();
    e = ev(0, 1, 8'h20, 8'h00, 8'hCD, 1, 3'd5, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL c80_call_opcode got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'hCD, 1, 3'd5, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL c80_opcode_hold got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h00, 0, 3'd5, S_WAIT2); n_checks++;
    if (obs() !== e) $display("FAIL c80_en_drop got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'hB4, 1, 3'd5, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL c80_adi1_low got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h00, 0, 3'd5, S_WAIT3); n_checks++;
    if (obs() !== e) $display("FAIL c80_wait3 got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h3F, 1, 3'd5, S_ACK3); n_checks++;
    if (obs() !== e) $display("FAIL c80_high_byte got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd5, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL c80_done got=%h exp=%h", obs(), e); else n_pass++;
    tick();
  endtask

  task automatic test_8080_adi0();
    mode_8086 = 1'b0; adi = 1'b0; hpi = 8'h08; call_addr_low = 3'b110; call_addr_high = 8'h3F;
    int_request = 1'b1; tick();
    inta_n = 1'b0; int_request = 1'b0; tick();
    e = ev(0, 1, 8'h08, 8'h00, 8'hCD, 1, 3'd3, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL adi0_first got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'hD8, 1, 3'd3, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL adi0_low got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd3, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL adi0_done got=%h exp=%h", obs(), e); else n_pass++;
    tick();
  endtask

  task automatic test_spurious();
    mode_8086 = 1'b1; aeoi = 1'b1; vector_base = 5'b01000; hpi = 8'h00;
    int_request = 1'b1; tick();
    inta_n = 1'b0; int_request = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h00, 0, 3'd7, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL spurious_level got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h47, 1, 3'd7, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL spurious_vector got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL spurious_no_eoi got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    aeoi = 1'b0;
  endtask

  task automatic test_withdraw();
    hpi = 8'h04; int_request = 1'b1; tick();
    e = ev(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7, S_REQ); n_checks++;
    if (obs() !== e) $display("FAIL withdraw_req got=%h exp=%h", obs(), e); else n_pass++;
    int_request = 1'b0; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL withdraw_idle got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd7, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL idle_inta_ignored got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
  endtask

  task automatic test_reset_mid();
    mode_8086 = 1'b0; adi = 1'b1; aeoi = 1'b1; hpi = 8'h20; call_addr_low = 3'b101;
    call_addr_high = 8'h3F; int_request = 1'b1; tick();
    inta_n = 1'b0; int_request = 1'b0; tick();
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'hB4, 1, 3'd5, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL rmid_in_ack2 got=%h exp=%h", obs(), e); else n_pass++;
    reset = 1'b1; inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL rmid_clears got=%h exp=%h", obs(), e); else n_pass++;
    reset = 1'b0; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL rmid_no_eoi got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL rmid_stray_inta got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    // fresh 8086 request, held high so a second request follows back to back
    mode_8086 = 1'b1; vector_base = 5'b01000; hpi = 8'h02; int_request = 1'b1; tick();
    e = ev(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd0, S_REQ); n_checks++;
    if (obs() !== e) $display("FAIL fresh_req got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h02, 8'h00, 8'h00, 0, 3'd1, S_ACK1); n_checks++;
    if (obs() !== e) $display("FAIL fresh_isr got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    inta_n = 1'b0; tick();
    e = ev(0, 1, 8'h00, 8'h00, 8'h41, 1, 3'd1, S_ACK2); n_checks++;
    if (obs() !== e) $display("FAIL fresh_vector got=%h exp=%h", obs(), e); else n_pass++;
    inta_n = 1'b1; tick();
    e = ev(0, 0, 8'h00, 8'h02, 8'h00, 0, 3'd1, S_DONE); n_checks++;
    if (obs() !== e) $display("FAIL fresh_eoi got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(0, 0, 8'h00, 8'h00, 8'h00, 0, 3'd1, S_IDLE); n_checks++;
    if (obs() !== e) $display("FAIL b2b_idle got=%h exp=%h", obs(), e); else n_pass++;
    tick();
    e = ev(1, 0, 8'h00, 8'h00, 8'h00, 0, 3'd1, S_REQ); n_checks++;
    if (obs() !== e) $display("FAIL back_to_back got=%h exp=%h", obs(), e); else n_pass++;
    int_request = 1'b0; aeoi = 1'b0; tick();
  endtask

  initial begin
    test_reset();
    test_8086_normal();
    test_8086_aeoi();
    test_8080_adi1();
    test_8080_adi0();
    test_spurious();
    test_withdraw();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
